debounce_multi: RTL and testbench

//  Parametrised multi-channel switch/button debouncer for board inputs feeding UART test controls.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_ch.sv | 138 +++++++++++++
 rtl/debounce_multi.sv | 68 ++++++
 tb/tb_debounce_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the multi-channel debouncer.
//   db_state_t    : per-channel hold-time FSM state
//   DB_MIN_SYNC   : fewest synchroniser flops a channel is ever built with
//   db_idle_state : settled state that matches a given debounced level
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int DB_MIN_SYNC = 2;

    function automatic db_state_t db_idle_state(input logic level);
        return level ? ONE : ZERO;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debouncer channel: input synchroniser, hold-time FSM and N-bit
// down-counter. The debounced level only moves after the synchronised input
// has sat at the new value for 2^N-1 consecutive clocks after the WAITx entry.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   sw_i         in   raw asynchronous switch input
//   level_o      out  registered debounced level
//   rise_o       out  registered one-cycle pulse on level 0->1
//   fall_o       out  registered one-cycle pulse on level 1->0
//   tick_next_o  out  rise/fall about to be registered (feeds the shared
//                     any_tick register so it lines up with rise_o/fall_o)
//
// state | meaning
// ------+----------------------------------------------------------
// ZERO  | settled low, waiting for the input to go high
// WAIT1 | input high, counting down the hold time before going high
// ONE   | settled high, waiting for the input to go low
// WAIT0 | input low, counting down the hold time before going low
// -----------------------------------------------------------------------------
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   N           = 22,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic tick_next_o
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_t    state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] cnt_dec;
    logic         level_q, level_d;
    logic         rise_q, rise_d;
    logic         fall_q, fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_dec = cnt_q - CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_MAX;
                end
            end
            WAIT1: begin
                if (!s) begin
                    // bounce: drop back without a tick; the counter is
                    // reloaded on the next WAIT1 entry
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = ONE;
                        rise_d  = 1'b1;
                    end
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_MAX;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = ZERO;
                        fall_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = db_idle_state(INIT_LEVEL);
            end
        endcase

        // level follows the settled side of the next state, so it switches
        // on the same edge that loads the tick register
        level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= db_idle_state(INIT_LEVEL);
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign tick_next_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// CH independent switch/button debouncers plus a shared "something changed"
// flag. Every output is registered; there is no combinational path from sw.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   sw         in   [CH-1:0] raw asynchronous switch/button inputs
//   db_level   out  [CH-1:0] debounced level per channel
//   rise_tick  out  [CH-1:0] one-cycle pulse on db_level 0->1
//   fall_tick  out  [CH-1:0] one-cycle pulse on db_level 1->0
//   any_tick   out  one-cycle pulse in any cycle that has a rise or fall tick
// -----------------------------------------------------------------------------
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   N           = 22,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick,
    output logic          any_tick
);

    // a single flop is not a synchroniser; never build fewer than two
    localparam int SYNC_EFF = (SYNC_STAGES < DB_MIN_SYNC) ? DB_MIN_SYNC : SYNC_STAGES;

    logic [CH-1:0] tick_next;
    logic          any_q, any_d;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        debounce_ch #(
            .N           (N),
            .SYNC_STAGES (SYNC_EFF),
            .INIT_LEVEL  (INIT_LEVEL)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .sw_i        (sw[gi]),
            .level_o     (db_level[gi]),
            .rise_o      (rise_tick[gi]),
            .fall_o      (fall_tick[gi]),
            .tick_next_o (tick_next[gi])
        );
    end

    // OR of the per-channel next ticks, registered so any_tick lands in the
    // same cycle as the rise/fall ticks it summarises
    assign any_d = |tick_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign any_tick = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

    localparam int CH   = 4;
    localparam int N    = 4;
    localparam int SS   = 2;
    localparam int HOLD = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] sw0, sw1;

    logic [CH-1:0] d_lvl  [2];
    logic [CH-1:0] d_rise [2];
    logic [CH-1:0] d_fall [2];
    logic          d_any  [2];

    int checks = 0;
    int errors = 0;

    debounce_multi #(.CH(CH), .N(N), .SYNC_STAGES(SS), .INIT_LEVEL(1'b0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw0),
        .db_level  (d_lvl[0]),
        .rise_tick (d_rise[0]),
        .fall_tick (d_fall[0]),
        .any_tick  (d_any[0])
    );

    debounce_multi #(.CH(CH), .N(N), .SYNC_STAGES(SS), .INIT_LEVEL(1'b1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw1),
        .db_level  (d_lvl[1]),
        .rise_tick (d_rise[1]),
        .fall_tick (d_fall[1]),
        .any_tick  (d_any[1])
    );

    always #5 clk = ~clk;

    // Reference model: each input reaches the decision point SS clocks after
    // it is sampled; the level flips once the delayed input has disagreed with
    // the level for HOLD+1 consecutive clocks.
    logic [CH-1:0] m_lvl  [2];
    logic [CH-1:0] m_rise [2];
    logic [CH-1:0] m_fall [2];
    logic          m_any  [2];
    int            run    [2][CH];
    logic [CH-1:0] hist   [2][SS];

    always @(posedge clk or posedge reset) begin : model
        logic [CH-1:0] smp;
        logic [CH-1:0] raw;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_lvl[i]  = (i == 1) ? '1 : '0;
                m_rise[i] = '0;
                m_fall[i] = '0;
                m_any[i]  = 1'b0;
                for (int k = 0; k < SS; k++) hist[i][k] = m_lvl[i];
                for (int c = 0; c < CH; c++) run[i][c] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                raw = (i == 0) ? sw0 : sw1;
                smp = hist[i][SS-1];
                for (int k = SS - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = raw;
                m_rise[i] = '0;
                m_fall[i] = '0;
                for (int c = 0; c < CH; c++) begin
                    if (smp[c] != m_lvl[i][c]) run[i][c]++;
                    else                       run[i][c] = 0;
                    if (run[i][c] == HOLD + 1) begin
                        run[i][c] = 0;
                        if (smp[c]) m_rise[i][c] = 1'b1;
                        else        m_fall[i][c] = 1'b1;
                        m_lvl[i][c] = smp[c];
                    end
                end
                m_any[i] = |(m_rise[i] | m_fall[i]);
            end
        end
    end

    int rise_cnt [2][CH];
    int fall_cnt [2][CH];
    int any_cnt  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            any_cnt[i] = 0;
            for (int c = 0; c < CH; c++) begin
                rise_cnt[i][c] = 0;
                fall_cnt[i][c] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({d_lvl[i], d_rise[i], d_fall[i], d_any[i]} !==
                    {m_lvl[i], m_rise[i], m_fall[i], m_any[i]}) begin
                    errors++;
                    $display("FAIL model_cmp inst%0d t=%0t got lvl=%b rise=%b fall=%b any=%b required lvl=%b rise=%b fall=%b any=%b",
                             i, $time, d_lvl[i], d_rise[i], d_fall[i], d_any[i],
                             m_lvl[i], m_rise[i], m_fall[i], m_any[i]);
                end
                for (int c = 0; c < CH; c++) begin
                    if (d_rise[i][c] === 1'b1) rise_cnt[i][c]++;
                    if (d_fall[i][c] === 1'b1) fall_cnt[i][c]++;
                end
                if (d_any[i] === 1'b1) any_cnt[i]++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        sw0   = '0;
        sw1   = '1;
        step(3);
        reset = 1'b0;
        chk("reset_db0", d_lvl[0], 4'b0000);
        chk("reset_db1", d_lvl[1], 4'b1111);
        chk("reset_ticks", {d_rise[0], d_fall[0], d_any[0], d_rise[1], d_fall[1], d_any[1]}, 0);

        // 1. idle, then reset in the middle of a WAIT1 hold
        step(50);
        chk("idle_db0", d_lvl[0], 4'b0000);
        chk("idle_any", any_cnt[0] + any_cnt[1], 0);
        sw0[0] = 1'b1;
        step(10);
        reset = 1'b1;
        step(1);
        chk("in_reset_db0", d_lvl[0], 4'b0000);
        sw0[0] = 1'b0;
        step(1);
        reset = 1'b0;
        step(30);
        chk("abort_no_rise", rise_cnt[0][0], 0);
        chk("abort_db0", d_lvl[0], 4'b0000);

        // 2. clean press on channel 0
        sw0[0] = 1'b1;
        step(17);
        chk("press_pre_db0", d_lvl[0], 4'b0000);
        step(1);
        chk("press_db0", d_lvl[0], 4'b0001);
        chk("press_rise0", d_rise[0], 4'b0001);
        chk("press_any0", d_any[0], 1);
        step(1);
        chk("press_rise_end", d_rise[0], 4'b0000);
        chk("press_any_end", d_any[0], 0);
        chk("press_rise_cnt", rise_cnt[0][0], 1);

        // 3. bouncing channel 1, then a clean hold high
        for (int t = 0; t < 12; t++) begin
            sw0[1] = ~sw0[1];
            step(5);
        end
        chk("bounce_no_rise", rise_cnt[0][1], 0);
        chk("bounce_no_fall", fall_cnt[0][1], 0);
        sw0[1] = 1'b1;
        step(17);
        chk("bounce_pre_db0", d_lvl[0], 4'b0001);
        step(1);
        chk("bounce_rise0", d_rise[0], 4'b0010);
        chk("bounce_db0", d_lvl[0], 4'b0011);
        step(5);
        chk("bounce_rise_cnt", rise_cnt[0][1], 1);

        // 4. release channel 0, then a release interrupted by a 1-clk glitch
        sw0[0] = 1'b0;
        step(17);
        chk("release_pre_db0", d_lvl[0], 4'b0011);
        step(1);
        chk("release_fall0", d_fall[0], 4'b0001);
        chk("release_db0", d_lvl[0], 4'b0010);
        sw0[0] = 1'b1;
        step(20);
        chk("repress_db0", d_lvl[0], 4'b0011);
        sw0[0] = 1'b0;
        step(13);
        sw0[0] = 1'b1;
        step(1);
        sw0[0] = 1'b0;
        step(17);
        chk("glitch_pre_db0", d_lvl[0], 4'b0011);
        chk("glitch_pre_fall", fall_cnt[0][0], 1);
        step(1);
        chk("glitch_fall0", d_fall[0], 4'b0001);
        chk("glitch_db0", d_lvl[0], 4'b0010);

        // 5. two channels rising on the same edge
        step(3);
        sw0[3:2] = 2'b11;
        step(17);
        chk("simul_pre_rise", d_rise[0], 4'b0000);
        step(1);
        chk("simul_rise0", d_rise[0], 4'b1100);
        chk("simul_any0", d_any[0], 1);
        chk("simul_db0", d_lvl[0], 4'b1110);
        step(1);
        chk("simul_any_end", d_any[0], 0);
        chk("total_any0", any_cnt[0], 6);
        chk("total_fall0", fall_cnt[0][0], 2);

        // 6. INIT_LEVEL=1 instance released on all channels
        sw1 = '0;
        step(17);
        chk("init1_pre_db1", d_lvl[1], 4'b1111);
        step(1);
        chk("init1_fall1", d_fall[1], 4'b1111);
        chk("init1_db1", d_lvl[1], 4'b0000);
        chk("init1_any1", d_any[1], 1);
        step(2);
        chk("init1_any_cnt", any_cnt[1], 1);

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
